// File: rtl/rc4_decryptor.sv
// RC4 PRGA stage: walks the shuffled S-RAM, swaps S[i]/S[j], XORs each keystream byte with a ROM byte.
// 9 cycles per byte; finished is a level held while start stays high, and dropping start aborts to IDLE.
module rc4_decryptor #(
  parameter int RAM_WIDTH  = 8,
  parameter int MSG_LENGTH = 32,
  localparam int AW = (MSG_LENGTH > 1) ? $clog2(MSG_LENGTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 finished,
  input  logic [RAM_WIDTH-1:0] ram_out,
  output logic                 write_enable,
  output logic [RAM_WIDTH-1:0] ram_in,
  output logic [RAM_WIDTH-1:0] address,
  output logic [AW-1:0]        rom_address,
  input  logic [RAM_WIDTH-1:0] rom_out,
  output logic [AW-1:0]        ans_address,
  output logic [RAM_WIDTH-1:0] ans_in,
  output logic                 ans_write_enable
);

  typedef enum logic [3:0] {
    IDLE, RD_SI, WT_SI, RD_SJ, WT_SJ, WR_SI, WR_SJ, RD_F, WT_F, WR_ANS, DONE
  } state_t;

  localparam logic [AW-1:0] LAST_K = AW'(MSG_LENGTH - 1);

  state_t               state_q, state_d;
  logic [RAM_WIDTH-1:0] i_q, i_d, j_q, j_d;
  logic [RAM_WIDTH-1:0] si_q, si_d, sj_q, sj_d;
  logic [RAM_WIDTH-1:0] f_q, f_d, enc_q, enc_d;
  logic [AW-1:0]        k_q, k_d;
  logic [RAM_WIDTH-1:0] addr_q;
  logic [AW-1:0]        rom_addr_q, ans_addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      si_q       <= '0;
      sj_q       <= '0;
      f_q        <= '0;
      enc_q      <= '0;
      k_q        <= '0;
      addr_q     <= '0;
      rom_addr_q <= '0;
      ans_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      f_q        <= f_d;
      enc_q      <= enc_d;
      k_q        <= k_d;
      addr_q     <= address;
      rom_addr_q <= rom_address;
      ans_addr_q <= ans_address;
    end
  end

  always_comb begin
    state_d          = state_q;
    i_d              = i_q;
    j_d              = j_q;
    si_d             = si_q;
    sj_d             = sj_q;
    f_d              = f_q;
    enc_d            = enc_q;
    k_d              = k_q;
    address          = addr_q;
    rom_address      = rom_addr_q;
    ans_address      = ans_addr_q;
    ram_in           = '0;
    write_enable     = 1'b0;
    ans_in           = '0;
    ans_write_enable = 1'b0;
    finished         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          i_d     = RAM_WIDTH'(1);
          j_d     = '0;
          k_d     = '0;
          state_d = RD_SI;
        end
      end
      RD_SI: begin
        address = i_q;
        state_d = WT_SI;
      end
      WT_SI: begin
        address = i_q;
        si_d    = ram_out;
        j_d     = j_q + ram_out;
        state_d = RD_SJ;
      end
      RD_SJ: begin
        address = j_q;
        state_d = WT_SJ;
      end
      WT_SJ: begin
        address = j_q;
        sj_d    = ram_out;
        state_d = WR_SI;
      end
      WR_SI: begin
        address      = i_q;
        ram_in       = sj_q;
        write_enable = 1'b1;
        state_d      = WR_SJ;
      end
      WR_SJ: begin
        address      = j_q;
        ram_in       = si_q;
        write_enable = 1'b1;
        state_d      = RD_F;
      end
      RD_F: begin
        address     = si_q + sj_q;
        rom_address = k_q;
        state_d     = WT_F;
      end
      WT_F: begin
        f_d     = ram_out;
        enc_d   = rom_out;
        state_d = WR_ANS;
      end
      WR_ANS: begin
        ans_address      = k_q;
        ans_in           = f_q ^ enc_q;
        ans_write_enable = 1'b1;
        if (k_q == LAST_K) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + AW'(1);
          i_d     = i_q + RAM_WIDTH'(1);
          state_d = RD_SI;
        end
      end
      DONE: begin
        finished = 1'b1;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Losing S-RAM ownership kills any strobe in the same cycle; the job restarts from scratch.
    if (state_q != IDLE && !start) begin
      state_d          = IDLE;
      write_enable     = 1'b0;
      ram_in           = '0;
      ans_write_enable = 1'b0;
      ans_in           = '0;
    end
  end

endmodule

// File: tb/tb_rc4_decryptor.sv
// Bench for rc4_decryptor (MSG_LENGTH=3) with behavioural S-RAM/ROM/answer RAM and a plain RC4 reference.
module tb_rc4_decryptor;

  localparam int L = 3;

  logic       clk, reset, start, finished;
  logic [7:0] ram_out, ram_in, address, rom_out, ans_in;
  logic       write_enable, ans_write_enable;
  logic [1:0] rom_address, ans_address;

  rc4_decryptor #(.RAM_WIDTH(8), .MSG_LENGTH(L)) dut (
    .clk(clk), .reset(reset), .start(start), .finished(finished),
    .ram_out(ram_out), .write_enable(write_enable), .ram_in(ram_in), .address(address),
    .rom_address(rom_address), .rom_out(rom_out), .ans_address(ans_address),
    .ans_in(ans_in), .ans_write_enable(ans_write_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] sram[256];
  logic [7:0] rom[4];
  logic [7:0] ans[4];
  logic [7:0] sram_img[256];
  logic [7:0] rom_img[4];
  logic [7:0] m_s[256];
  logic [7:0] exp_ans[L];
  logic       load;

  always @(posedge clk) begin
    if (load) begin
      sram <= sram_img;
      rom  <= rom_img;
      for (int x = 0; x < 4; x++) ans[x] <= 8'hEE;
    end else begin
      if (write_enable) sram[address] <= ram_in;
      if (ans_write_enable) ans[ans_address] <= ans_in;
    end
    ram_out <= sram[address];
    rom_out <= rom[rom_address];
  end

  int both_cnt = 0, seq_bad = 0, ans_wr_cnt = 0, exp_idx = 0;
  always @(negedge clk) begin
    if (write_enable && ans_write_enable) both_cnt++;
    if (!start) exp_idx = 0;
    else if (ans_write_enable) begin
      if (int'(ans_address) != exp_idx) seq_bad++;
      exp_idx++;
      ans_wr_cnt++;
    end
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Textbook RC4 keystream over m_s (i starts at 0 and pre-increments); m_s ends as the final S.
  task automatic model_prga();
    int i, j;
    logic [7:0] t;
    i = 0; j = 0;
    for (int n = 0; n < L; n++) begin
      i = (i + 1) % 256;
      j = (j + int'(m_s[i])) % 256;
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      exp_ans[n] = m_s[(int'(m_s[i]) + int'(m_s[j])) % 256] ^ rom_img[n];
    end
  endtask

  task automatic load_mem();
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic prep_identity(input logic [7:0] fill);
    for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
    for (int x = 0; x < 4; x++) rom_img[x] = fill;
    sram_img = m_s;
    model_prga();
    load_mem();
  endtask

  task automatic prep_key(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
    logic [7:0] key[3];
    logic [7:0] t;
    int j;
    key[0] = k0; key[1] = k1; key[2] = k2;
    for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
    j = 0;
    for (int x = 0; x < 256; x++) begin
      j = (j + int'(m_s[x]) + int'(key[x % 3])) % 256;
      t = m_s[x]; m_s[x] = m_s[j]; m_s[j] = t;
    end
    for (int x = 0; x < 4; x++) rom_img[x] = 8'($urandom_range(0, 255));
    sram_img = m_s;
    model_prga();
    load_mem();
  endtask

  task automatic run_dec(input string tag, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    int lat, b0, s0, w0, bad;
    b0 = both_cnt; s0 = seq_bad; w0 = ans_wr_cnt;
    lat = 0;
    start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (finished) begin lat = c; break; end
    end
    chk({tag, "_latency"}, 32'(lat), 32'd28);
    @(posedge clk); #1;
    chk({tag, "_finished_held"}, 32'(finished), 32'd1);
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_finished_drop"}, 32'(finished), 32'd0);
    chk({tag, "_ans0"}, 32'(ans[0]), 32'(e0));
    chk({tag, "_ans1"}, 32'(ans[1]), 32'(e1));
    chk({tag, "_ans2"}, 32'(ans[2]), 32'(e2));
    bad = 0;
    for (int x = 0; x < 256; x++) if (sram[x] !== m_s[x]) bad++;
    chk({tag, "_sram_final"}, 32'(bad), 32'd0);
    chk({tag, "_both_strobes"}, 32'(both_cnt - b0), 32'd0);
    chk({tag, "_ans_addr_seq"}, 32'(seq_bad - s0), 32'd0);
    chk({tag, "_ans_writes"}, 32'(ans_wr_cnt - w0), 32'(L));
  endtask

  typedef struct {
    logic [7:0] rom_fill;
    logic [7:0] exp0, exp1, exp2;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int   bad, w0;
    tbl[0] = '{8'h00, 8'h02, 8'h05, 8'h07};
    tbl[1] = '{8'hFF, 8'hFD, 8'hFA, 8'hF8};
    tbl[2] = '{8'h5A, 8'h58, 8'h5F, 8'h5D};
    tbl[3] = '{8'h3C, 8'h3E, 8'h39, 8'h3B};

    reset = 1'b0; start = 1'b0; load = 1'b0;
    #2;
    chk("reset_outputs",
        32'({finished, write_enable, ans_write_enable, ram_in, address, rom_address, ans_address, ans_in}), 32'd0);
    #20 reset = 1'b1;
    @(posedge clk); #1;

    // Identity S-RAM with uniform ROM fills: expectations are hand-derived constants.
    for (int v = 0; v < 4; v++) begin
      prep_identity(tbl[v].rom_fill);
      run_dec($sformatf("tbl%0d", v), tbl[v].exp0, tbl[v].exp1, tbl[v].exp2);
      if (v == 0) begin
        chk("ident_s2", 32'(sram[2]), 32'h03);
        chk("ident_s3", 32'(sram[3]), 32'h05);
        chk("ident_s5", 32'(sram[5]), 32'h02);
      end
    end

    // KSA-shuffled S-RAM (zero key first, then random keys) and random ciphertext.
    for (int r = 0; r < 6; r++) begin
      if (r == 0) prep_key(8'h00, 8'h00, 8'h00);
      else prep_key(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      run_dec($sformatf("rnd%0d", r), exp_ans[0], exp_ans[1], exp_ans[2]);
    end

    // Abort: drop start while the first S[i] write is on the bus.
    prep_identity(8'h00);
    w0 = ans_wr_cnt;
    start = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (write_enable) break;
    end
    chk("abort_reached_wr", 32'(write_enable), 32'd1);
    start = 1'b0;
    #1;
    chk("abort_we_gated", 32'(write_enable), 32'd0);
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (write_enable || ans_write_enable || finished) bad++;
    end
    chk("abort_quiet", 32'(bad), 32'd0);
    chk("abort_no_ans", 32'(ans_wr_cnt - w0), 32'd0);
    prep_identity(8'h00);
    run_dec("abort_restart", 8'h02, 8'h05, 8'h07);

    // Asynchronous reset pulse while waiting on the final read of byte 0.
    prep_identity(8'hFF);
    w0 = ans_wr_cnt;
    start = 1'b1;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (write_enable) bad++;
      if (bad == 2) break;
    end
    chk("rst_reached_wr_sj", 32'(bad), 32'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    #1;
    chk("rst_async_outputs",
        32'({finished, write_enable, ans_write_enable, ram_in, address, rom_address, ans_address, ans_in}), 32'd0);
    #5 reset = 1'b1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (write_enable || ans_write_enable || finished || address != 8'h00) bad++;
    end
    chk("rst_idle_quiet", 32'(bad), 32'd0);
    chk("rst_no_ans", 32'(ans_wr_cnt - w0), 32'd0);
    prep_identity(8'hFF);
    run_dec("rst_restart", 8'hFD, 8'hFA, 8'hF8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
